// File: rtl/bit_serializer_if.sv
// Handshake bundle for bit_serializer: parallel word input side and serial bit output side.
// The slave modport is the serializer's view; the master modport is the producer/consumer view.
interface bit_serializer_if #(
   parameter int unsigned WIDTH = 8
);
   logic             word_valid;
   logic [WIDTH-1:0] word_data;
   logic             word_ready;
   logic             bit_ready;
   logic             bit_valid;
   logic             bit_out;
   logic             bit_first;
   logic             bit_last;
   logic             busy;

   modport master (
      output word_valid, word_data, bit_ready,
      input  word_ready, bit_valid, bit_out, bit_first, bit_last, busy
   );

   modport slave (
      input  word_valid, word_data, bit_ready,
      output word_ready, bit_valid, bit_out, bit_first, bit_last, busy
   );
endinterface

// File: rtl/bit_serializer.sv
// Parallel-to-serial transmitter: LSB-first bit stream with first/last framing and a one-word
// holding buffer so consecutive words stream without a gap.
module bit_serializer #(
   parameter int unsigned WIDTH = 8
) (
   input  logic            clk,
   input  logic            rstn,
   input  logic            en,
   bit_serializer_if.slave bus
);
   localparam int unsigned     IdxW    = $clog2(WIDTH);
   localparam logic [IdxW-1:0] LastIdx = IdxW'(WIDTH - 1);

   typedef enum logic {StIdle, StShift} state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] hold_q, hold_d;
   logic             hold_valid_q, hold_valid_d;
   logic [WIDTH-1:0] sreg_q, sreg_d;
   logic [IdxW-1:0]  bit_index_q, bit_index_d;
   logic             step;
   logic             accept;

   always_comb begin
      state_d      = state_q;
      hold_d       = hold_q;
      hold_valid_d = hold_valid_q;
      sreg_d       = sreg_q;
      bit_index_d  = bit_index_q;

      step   = (state_q == StShift) && en && bus.bit_ready;
      accept = bus.word_valid && !hold_valid_q;

      // Accept requires an empty buffer and drain requires a full one, so they never collide.
      if (accept) begin
         hold_d       = bus.word_data;
         hold_valid_d = 1'b1;
      end

      unique case (state_q)
         StIdle: begin
            if (hold_valid_q) begin
               sreg_d       = hold_q;
               bit_index_d  = '0;
               hold_valid_d = 1'b0;
               state_d      = StShift;
            end
         end
         StShift: begin
            if (step) begin
               if (bit_index_q == LastIdx) begin
                  bit_index_d = '0;
                  if (hold_valid_q) begin
                     sreg_d       = hold_q;
                     hold_valid_d = 1'b0;
                  end else begin
                     state_d = StIdle;
                  end
               end else begin
                  sreg_d      = {1'b0, sreg_q[WIDTH-1:1]};
                  bit_index_d = bit_index_q + IdxW'(1);
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q      <= StIdle;
         hold_q       <= '0;
         hold_valid_q <= 1'b0;
         sreg_q       <= '0;
         bit_index_q  <= '0;
      end else begin
         state_q      <= state_d;
         hold_q       <= hold_d;
         hold_valid_q <= hold_valid_d;
         sreg_q       <= sreg_d;
         bit_index_q  <= bit_index_d;
      end
   end

   // Outputs decode registered state only; no input reaches an output combinationally.
   assign bus.word_ready = !hold_valid_q;
   assign bus.bit_valid  = (state_q == StShift);
   assign bus.bit_out    = sreg_q[0] & bus.bit_valid;
   assign bus.bit_first  = bus.bit_valid && (bit_index_q == '0);
   assign bus.bit_last   = bus.bit_valid && (bit_index_q == LastIdx);
   assign bus.busy       = bus.bit_valid || hold_valid_q;
endmodule

// File: tb/tb_bit_serializer.sv
// Scoreboard bench for bit_serializer: accepted words expand into expected framed bits in a queue;
// a negedge monitor checks every presented bit and the occupancy-derived handshake outputs.
module tb_bit_serializer;
   localparam int unsigned W = 8;

   typedef struct packed {
      logic b;
      logic f;
      logic l;
   } exp_t;

   logic clk  = 1'b0;
   logic rstn = 1'b0;
   logic en   = 1'b0;

   bit_serializer_if #(.WIDTH(W)) bus ();

   bit_serializer #(.WIDTH(W)) dut (
      .clk  (clk),
      .rstn (rstn),
      .en   (en),
      .bus  (bus.slave)
   );

   always #5 clk = ~clk;

   exp_t           q[$];
   logic [W-1:0]   src[$];
   int             checks    = 0;
   int             errors    = 0;
   bit             acc_flag  = 1'b0;
   bit             mon_on    = 1'b0;
   int             offer_pct = 100;
   int             m_pend;
   logic           m_bv;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: a word becomes W bits, LSB first, framed on bit 0 and bit W-1.
   task automatic push_word(input logic [W-1:0] w);
      exp_t e;
      for (int k = 0; k < int'(W); k++) begin
         e.b = w[k];
         e.f = (k == 0);
         e.l = (k == int'(W) - 1);
         q.push_back(e);
      end
   endtask

   task automatic drive_offer();
      if (src.size() > 0 && $urandom_range(99) < offer_pct) begin
         bus.word_valid = 1'b1;
         bus.word_data  = src[0];
      end else begin
         bus.word_valid = 1'b0;
         bus.word_data  = W'($urandom);
      end
   endtask

   task automatic cycle();
      bit will;
      @(negedge clk);
      will = rstn && bus.word_valid && bus.word_ready;
      @(posedge clk);
      acc_flag = will;
      if (will) push_word(src.pop_front());
      #1;
      drive_offer();
   endtask

   task automatic drain(input int max, input bit rnd);
      int n = 0;
      while ((q.size() > 0 || src.size() > 0) && n < max) begin
         if (rnd) begin
            en            = ($urandom_range(3) != 0);
            bus.bit_ready = ($urandom_range(3) != 0);
         end
         cycle();
         n++;
      end
      en            = 1'b1;
      bus.bit_ready = 1'b1;
      chk("drain_timeout", 32'(q.size() + src.size()), 32'd0);
      repeat (2) cycle();
   endtask

   task automatic reset_checks(input string tag);
      chk({tag, "_bit_valid"}, 32'(bus.bit_valid), 32'd0);
      chk({tag, "_bit_out"}, 32'(bus.bit_out), 32'd0);
      chk({tag, "_bit_first"}, 32'(bus.bit_first), 32'd0);
      chk({tag, "_bit_last"}, 32'(bus.bit_last), 32'd0);
      chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
      chk({tag, "_word_ready"}, 32'(bus.word_ready), 32'd1);
   endtask

   // Expected bit_valid: bits are pending, except the cycle right after a word was accepted into
   // an otherwise empty pipeline (the load edge is still ahead).
   always @(negedge clk) begin
      if (rstn && mon_on) begin
         m_bv   = (q.size() > 0) && !(acc_flag && q.size() == int'(W));
         m_pend = (q.size() + int'(W) - 1) / int'(W);
         chk("bit_valid", 32'(bus.bit_valid), 32'(m_bv));
         chk("busy", 32'(bus.busy), 32'(q.size() > 0));
         chk("word_ready", 32'(bus.word_ready), 32'((m_pend - int'(m_bv)) == 0));
         if (bus.bit_valid && q.size() > 0) begin
            chk("bit_out", 32'(bus.bit_out), 32'(q[0].b));
            chk("bit_first", 32'(bus.bit_first), 32'(q[0].f));
            chk("bit_last", 32'(bus.bit_last), 32'(q[0].l));
            if (en && bus.bit_ready) void'(q.pop_front());
         end else begin
            chk("idle_outputs", 32'({bus.bit_out, bus.bit_first, bus.bit_last}), 32'd0);
         end
      end
   end

   initial begin
      bus.word_valid = 1'b0;
      bus.word_data  = '0;
      bus.bit_ready  = 1'b0;
      #12;
      reset_checks("reset");
      @(negedge clk);
      rstn = 1'b1;
      @(posedge clk);
      #1;
      mon_on        = 1'b1;
      en            = 1'b1;
      bus.bit_ready = 1'b1;

      // Single word
      src.push_back(8'hA5);
      drain(100, 1'b0);

      // Back-to-back: second word offered while the first shifts
      src.push_back(8'hA5);
      src.push_back(8'h3C);
      drain(100, 1'b0);

      // Stalls: bit_ready low around bit 2, en low around bit 5
      src.push_back(8'h81);
      repeat (4) cycle();
      bus.bit_ready = 1'b0;
      repeat (3) cycle();
      bus.bit_ready = 1'b1;
      repeat (3) cycle();
      en = 1'b0;
      repeat (2) cycle();
      en = 1'b1;
      drain(100, 1'b0);

      // Buffer full: 0xFF held valid while a word shifts and hold is occupied
      src.push_back(8'h11);
      src.push_back(8'h22);
      src.push_back(8'hFF);
      drain(100, 1'b0);

      // Asynchronous reset mid-word with hold occupied
      src.push_back(8'hA5);
      src.push_back(8'h3C);
      repeat (5) cycle();
      #2;
      rstn   = 1'b0;
      mon_on = 1'b0;
      #1;
      reset_checks("midreset");
      q.delete();
      src.delete();
      bus.word_valid = 1'b0;
      acc_flag       = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rstn = 1'b1;
      @(posedge clk);
      #1;
      mon_on = 1'b1;
      src.push_back(8'h01);
      drain(100, 1'b0);

      // Randomized traffic with independent en / bit_ready stalls and producer gaps
      offer_pct = 70;
      for (int i = 0; i < 300; i++) src.push_back(W'($urandom));
      drain(20000, 1'b1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
